// File: rtl/riscv_test_pkg.sv
// Shared encodings for the riscv-tests end-of-test monitor: verdict codes,
// monitor states and default addresses.
package riscv_test_pkg;

    localparam logic [2:0] VERDICT_NONE    = 3'd0;
    localparam logic [2:0] VERDICT_PASS    = 3'd1;
    localparam logic [2:0] VERDICT_FAIL    = 3'd2;
    localparam logic [2:0] VERDICT_TIMEOUT = 3'd3;
    localparam logic [2:0] VERDICT_HANG    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [31:0] DEFAULT_END_PC      = 32'h0000_0044;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter with async reset, synchronous clear and increment enable.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: end-PC, timeout and hang detection with a sticky verdict.
// Optional tohost store detection is enabled by defining RISCV_TEST_MONITOR_TOHOST_EN.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] END_PC         = XLEN'(DEFAULT_END_PC),
    parameter logic [XLEN-1:0] PASS_VALUE     = XLEN'(1),
    parameter int              TIMEOUT_CYCLES = 5000,
    parameter int              HANG_CYCLES    = 64,
    parameter int              CNT_W          = 32
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    ,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  gp,
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
`endif
    output logic             done,
    output logic             pass,
    output logic [2:0]       verdict,
    output logic [XLEN-2:0]  fail_testnum,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int               HW        = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
    localparam logic [HW-1:0]    HANG_LAST = HW'((HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [2:0]      r_verdict;
    logic [XLEN-2:0] r_fail_testnum;
    logic [XLEN-1:0] r_last_pc;

    logic [CNT_W-1:0] w_cycle_cnt;
    logic [HW-1:0]    w_hang_cnt;
    logic             w_active;
    logic             w_match;
    logic             w_end_pc;
    logic             w_timeout;
    logic             w_hang;
    logic             w_tohost;
    logic             w_finish;

    // A paused (en=0) or clearing RUN cycle neither counts nor detects.
    assign w_active  = (r_state == ST_RUN) && en && !clear;
    assign w_match   = pc_valid && (pc == r_last_pc);
    assign w_end_pc  = pc_valid && (pc == END_PC);
    assign w_timeout = (w_cycle_cnt == TO_LAST);
    assign w_hang    = (HANG_CYCLES != 0) && w_match && (w_hang_cnt == HANG_LAST);
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    assign w_tohost  = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
`else
    assign w_tohost  = 1'b0;
`endif
    assign w_finish  = w_tohost || w_end_pc || w_timeout || w_hang;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clear),
        .i_inc (w_active && !w_finish),
        .o_cnt (w_cycle_cnt)
    );

    sat_counter #(.W(HW)) u_hang_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clear || (w_active && !w_match)),
        .i_inc (w_active && w_match),
        .o_cnt (w_hang_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_pc <= '0;
        end else if (clear) begin
            r_last_pc <= '0;
        end else if (w_active && pc_valid) begin
            r_last_pc <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_verdict      <= VERDICT_NONE;
            r_fail_testnum <= '0;
        end else if (clear) begin
            r_state        <= ST_IDLE;
            r_verdict      <= VERDICT_NONE;
            r_fail_testnum <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_active && w_finish) begin
                        r_state <= ST_DONE;
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
                        if (w_tohost) begin
                            if (st_data == XLEN'(1)) begin
                                r_verdict <= VERDICT_PASS;
                            end else begin
                                r_verdict      <= VERDICT_FAIL;
                                r_fail_testnum <= st_data[XLEN-1:1];
                            end
                        end else
`endif
                        if (w_end_pc) begin
                            if (gp == PASS_VALUE) begin
                                r_verdict <= VERDICT_PASS;
                            end else begin
                                r_verdict      <= VERDICT_FAIL;
                                r_fail_testnum <= gp[XLEN-1:1];
                            end
                        end else if (w_timeout) begin
                            r_verdict <= VERDICT_TIMEOUT;
                        end else begin
                            r_verdict <= VERDICT_HANG;
                        end
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    assign verdict      = r_verdict;
    assign done         = (r_verdict != VERDICT_NONE);
    assign pass         = (r_verdict == VERDICT_PASS);
    assign fail_testnum = r_fail_testnum;
    assign cycle_count  = w_cycle_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: end-PC vector table plus timeout,
// hang, pause, clear and async-reset sequences.
module tb_riscv_test_monitor;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clear;
    logic             pc_valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  gp;
    logic             done;
    logic             pass;
    logic [2:0]       verdict;
    logic [XLEN-2:0]  fail_testnum;
    logic [CNT_W-1:0] cycle_count;
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    logic             st_valid;
    logic [XLEN-1:0]  st_addr;
    logic [XLEN-1:0]  st_data;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    riscv_test_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clear        (clear),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .gp           (gp),
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
`endif
        .done         (done),
        .pass         (pass),
        .verdict      (verdict),
        .fail_testnum (fail_testnum),
        .cycle_count  (cycle_count)
    );

    typedef struct {
        int              n_steps;
        logic [XLEN-1:0] gp_val;
        logic [2:0]      exp_verdict;
        logic            exp_pass;
        logic [XLEN-2:0] exp_testnum;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clear, then enable; the enabling edge moves IDLE->RUN without counting.
    task automatic start_run();
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        en       = 1'b1;
        pc_valid = 1'b1;
        gp       = '0;
        pc       = 32'h200;
        tick();
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            pc = pc + 32'd4;
            tick();
        end
    endtask

    initial begin
        int edges;

        rst = 1'b1; en = 1'b0; clear = 1'b0; pc_valid = 1'b0; pc = '0; gp = '0;
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        st_valid = 1'b0; st_addr = '0; st_data = '0;
`endif
        #12;
        check("reset_done",    done,         0);
        check("reset_verdict", verdict,      0);
        check("reset_count",   cycle_count,  0);
        check("reset_testnum", fail_testnum, 0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{20, 32'd1,          3'd1, 1'b1, 31'd0};
        vecs[1] = '{20, 32'd7,          3'd2, 1'b0, 31'd3};
        vecs[2] = '{3,  32'd0,          3'd2, 1'b0, 31'd0};
        vecs[3] = '{0,  32'h8000_0001,  3'd2, 1'b0, 31'h4000_0000};
        vecs[4] = '{7,  32'd3,          3'd2, 1'b0, 31'd1};

        for (int v = 0; v < 5; v++) begin
            start_run();
            step(vecs[v].n_steps);
            check($sformatf("v%0d_pre_done", v),  done,        0);
            check($sformatf("v%0d_pre_count", v), cycle_count, vecs[v].n_steps);
            pc = 32'h44;
            gp = vecs[v].gp_val;
            tick();
            check($sformatf("v%0d_done", v),    done,         1);
            check($sformatf("v%0d_pass", v),    pass,         vecs[v].exp_pass);
            check($sformatf("v%0d_verdict", v), verdict,      vecs[v].exp_verdict);
            check($sformatf("v%0d_testnum", v), fail_testnum, vecs[v].exp_testnum);
            check($sformatf("v%0d_count", v),   cycle_count,  vecs[v].n_steps);
            pc = 32'h300;
            gp = 32'd1;
            tick();
            check($sformatf("v%0d_sticky", v), verdict,     vecs[v].exp_verdict);
            check($sformatf("v%0d_frozen", v), cycle_count, vecs[v].n_steps);
        end

        // Timeout: pc keeps moving and never reaches END_PC.
        start_run();
        edges = 0;
        while (!done && edges < 6000) begin
            pc = pc + 32'd4;
            tick();
            edges++;
        end
        check("to_edges",   edges,       5000);
        check("to_verdict", verdict,     3);
        check("to_pass",    pass,        0);
        check("to_count",   cycle_count, 4999);
        step(3);
        check("to_frozen",  cycle_count, 4999);

        // Pause with en=0, then clear together with en.
        start_run();
        step(5);
        check("pause_before", cycle_count, 5);
        en = 1'b0;
        step(4);
        check("pause_hold", cycle_count, 5);
        check("pause_done", done,        0);
        en = 1'b1;
        step(1);
        check("pause_resume", cycle_count, 6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_en_count", cycle_count, 0);
        step(1);
        check("clr_en_idle", cycle_count, 0);
        step(1);
        check("clr_en_run", cycle_count, 1);
        pc_valid = 1'b0;
        pc = 32'h44;
        gp = 32'd1;
        tick();
        check("invalid_endpc", done, 0);
        pc_valid = 1'b1;
        pc = 32'h500;

        // Hang: 1 first sample plus 64 identical repeats.
        start_run();
        pc = 32'h30;
        repeat (64) tick();
        check("hang_pre", done, 0);
        tick();
        check("hang_verdict", verdict,     4);
        check("hang_pass",    pass,        0);
        check("hang_count",   cycle_count, 64);

        // Hang count restarts after pc_valid drops.
        start_run();
        pc = 32'h30;
        repeat (40) tick();
        pc_valid = 1'b0;
        tick();
        pc_valid = 1'b1;
        repeat (63) tick();
        check("hang_restart_pre", done, 0);
        tick();
        check("hang_restart_verdict", verdict, 4);

        // Async reset between edges.
        start_run();
        step(100);
        check("ar_count_before", cycle_count, 100);
        #2;
        rst = 1'b1;
        #1;
        check("ar_done",    done,        0);
        check("ar_verdict", verdict,     0);
        check("ar_count",   cycle_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clear after PASS, then rerun.
        start_run();
        step(4);
        pc = 32'h44;
        gp = 32'd1;
        tick();
        check("clr_pass_first", pass, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_done",    done,        0);
        check("clr_verdict", verdict,     0);
        check("clr_count",   cycle_count, 0);
        en = 1'b1;
        pc = 32'h200;
        gp = '0;
        tick();
        step(2);
        pc = 32'h44;
        gp = 32'd1;
        tick();
        check("rerun_pass",  pass,        1);
        check("rerun_count", cycle_count, 2);

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        start_run();
        step(3);
        pc       = 32'h44;
        gp       = 32'd1;
        st_valid = 1'b1;
        st_addr  = 32'h1000;
        st_data  = 32'd5;
        tick();
        st_valid = 1'b0;
        check("tohost_verdict", verdict,      2);
        check("tohost_testnum", fail_testnum, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
